// File: rtl/sysid_verifier.sv
`default_nettype none
// ============================================================================
// Module   : sysid_verifier
// Brief    : Avalon-MM read master that fetches the system-ID and build
//            timestamp words and checks them against build-time values.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_verifier #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1398725577,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_ID  = 3'd1,
    S_WAIT_ID = 3'd2,
    S_REQ_TS  = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // The stall that would bring the counter to TIMEOUT_CYCLES ends the read.
  localparam logic [15:0] c_stall_last = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  c_lat_load   = 2'(READ_LATENCY - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_armed;
  logic [15:0] r_stall;
  logic [1:0]  r_lat;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic        w_start_req;
  logic        w_in_req;
  logic        w_in_wait;
  logic        w_accept;
  logic        w_expire;
  logic        w_capture_id;
  logic        w_capture_ts;
  logic        w_enter_req;
  logic        w_enter_req_id;

  always_comb begin
    w_next_state = r_state;
    w_in_req     = 1'b0;
    w_in_wait    = 1'b0;
    w_expire     = 1'b0;
    w_capture_id = 1'b0;
    w_capture_ts = 1'b0;
    avm_read     = 1'b0;
    avm_address  = 1'b0;
    busy         = 1'b0;
    // r_armed is low only until the first edge after reset release.
    w_start_req  = start | (AUTO_START & ~r_armed);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_req) w_next_state = S_REQ_ID;
      end
      S_REQ_ID: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        w_in_req = 1'b1;
        if (!avm_waitrequest) begin
          w_next_state = S_WAIT_ID;
        end else if (r_stall == c_stall_last) begin
          w_expire     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_WAIT_ID: begin
        busy      = 1'b1;
        w_in_wait = 1'b1;
        if (r_lat == 2'd0) begin
          w_capture_id = 1'b1;
          w_next_state = S_REQ_TS;
        end
      end
      S_REQ_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        busy        = 1'b1;
        w_in_req    = 1'b1;
        if (!avm_waitrequest) begin
          w_next_state = S_WAIT_TS;
        end else if (r_stall == c_stall_last) begin
          w_expire     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_WAIT_TS: begin
        avm_address = 1'b1;
        busy        = 1'b1;
        w_in_wait   = 1'b1;
        if (r_lat == 2'd0) begin
          w_capture_ts = 1'b1;
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    w_accept       = w_in_req & ~avm_waitrequest;
    w_enter_req    = ((w_next_state == S_REQ_ID) || (w_next_state == S_REQ_TS)) &&
                     (w_next_state != r_state);
    w_enter_req_id = (w_next_state == S_REQ_ID) && (r_state != S_REQ_ID);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_armed    <= 1'b0;
      r_stall    <= 16'd0;
      r_lat      <= 2'd0;
      r_done     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else begin
      r_armed <= 1'b1;

      if (w_enter_req) begin
        r_stall <= 16'd0;
      end else if (w_in_req && avm_waitrequest) begin
        r_stall <= r_stall + 16'd1;
      end

      if (w_accept) begin
        r_lat <= c_lat_load;
      end else if (w_in_wait && (r_lat != 2'd0)) begin
        r_lat <= r_lat - 2'd1;
      end

      if (w_enter_req_id) begin
        r_done    <= 1'b0;
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
      end

      if (w_capture_id) begin
        r_id_value <= avm_readdata;
        r_id_ok    <= (avm_readdata == EXPECTED_ID);
      end

      if (w_capture_ts) begin
        r_ts_value <= avm_readdata;
        r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
        r_done     <= 1'b1;
      end

      // Captured words are kept, but a timed-out check never reports a pass.
      if (w_expire) begin
        r_timeout <= 1'b1;
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  assign done     = r_done;
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_verifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_verifier
// Brief    : Randomised scoreboard bench for sysid_verifier with a latency-
//            accurate Avalon slave and a higher-level expected-result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_verifier;

  localparam int          RL     = 3;
  localparam int          TO     = 4;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1398725577;

  typedef struct {
    logic [31:0] id_v;
    logic [31:0] ts_v;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    int          lat;
  } res_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata = 32'd0;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  always #5 clock = ~clock;

  sysid_verifier #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY      (RL),
    .TIMEOUT_CYCLES    (TO),
    .AUTO_START        (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  // Slave: stalls the first N edges of each request, returns the word only
  // on the RL-th edge after acceptance and random garbage at all other times.
  logic [31:0] slv_id_data  = 32'd0;
  logic [31:0] slv_ts_data  = 32'd0;
  int unsigned slv_stall_id = 0;
  int unsigned slv_stall_ts = 0;
  int unsigned stall_cnt    = 0;
  int          rem          = 0;
  logic [31:0] pend_data    = 32'd0;

  assign avm_waitrequest = avm_read &&
                           (stall_cnt < (avm_address ? slv_stall_ts : slv_stall_id));

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else                             stall_cnt <= 0;

    if (avm_read && !avm_waitrequest) begin
      rem          <= RL;
      pend_data    <= avm_address ? slv_ts_data : slv_id_data;
      avm_readdata <= (RL == 1) ? (avm_address ? slv_ts_data : slv_id_data) : $urandom;
    end else if (rem > 1) begin
      rem          <= rem - 1;
      avm_readdata <= (rem == 2) ? pend_data : $urandom;
    end else begin
      rem          <= 0;
      avm_readdata <= $urandom;
    end
  end

  // Scoreboard state
  res_t exp_q[$];
  logic addr_q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   completions = 0;
  int   bound_fail  = 0;
  bit   end_req     = 1'b0;
  bit   end_ack     = 1'b0;
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  bit   prev_busy  = 1'b0;
  bit   prev_stall = 1'b0;
  logic prev_addr  = 1'b0;
  int   busy_cnt   = 0;

  initial begin
    res_t r;
    logic a;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("reset_flags", 64'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 64'd0);
        chk("reset_values", {id_value, ts_value}, 64'd0);
        prev_busy  = 1'b0;
        prev_stall = 1'b0;
        busy_cnt   = 0;
      end else begin
        if (prev_stall && !timeout)
          chk("stall_hold", 64'({avm_read, avm_address}), 64'({1'b1, prev_addr}));
        if (busy && !prev_busy)
          chk("start_clears", 64'({done, id_ok, ts_ok, timeout}), 64'd0);
        if (avm_read && !avm_waitrequest) begin
          chk("read_expected", 64'(addr_q.size() != 0), 64'd1);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            chk("read_addr", 64'(avm_address), 64'(a));
          end
        end
        if (busy) busy_cnt++;
        if (prev_busy && !busy) begin
          chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("done",     64'(done),     64'd1);
            chk("id_ok",    64'(id_ok),    64'(r.id_ok));
            chk("ts_ok",    64'(ts_ok),    64'(r.ts_ok));
            chk("timeout",  64'(timeout),  64'(r.tmo));
            chk("id_value", 64'(id_value), 64'(r.id_v));
            chk("ts_value", 64'(ts_value), 64'(r.ts_v));
            chk("latency",  64'(busy_cnt), 64'(r.lat));
          end
          completions++;
          busy_cnt = 0;
        end
        prev_busy  = busy;
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
      end
      if (end_req && !end_ack) begin
        chk("reads_left",   64'(addr_q.size()), 64'd0);
        chk("results_left", 64'(exp_q.size()),  64'd0);
        chk("waits_expired", 64'(bound_fail),   64'd0);
        end_ack = 1'b1;
      end
    end
  end

  // Reference model: what one check should produce, from the slave setup.
  task automatic expect_run(input logic [31:0] idd, input logic [31:0] tsd,
                            input int sid, input int sts);
    res_t r;
    slv_id_data  = idd;
    slv_ts_data  = tsd;
    slv_stall_id = sid;
    slv_stall_ts = sts;
    r.tmo = 1'b1;
    if (sid >= TO) begin
      r.lat = TO;
    end else begin
      addr_q.push_back(1'b0);
      m_id = idd;
      if (sts >= TO) begin
        r.lat = sid + 1 + RL + TO;
      end else begin
        addr_q.push_back(1'b1);
        m_ts  = tsd;
        r.tmo = 1'b0;
        r.lat = sid + sts + 2 * (1 + RL);
      end
    end
    r.id_ok = !r.tmo && (idd == EXP_ID);
    r.ts_ok = !r.tmo && (tsd == EXP_TS);
    r.id_v  = m_id;
    r.ts_v  = m_ts;
    exp_q.push_back(r);
  endtask

  task automatic wait_done(input int c0);
    int i;
    i = 0;
    while (completions == c0 && i < 300) begin
      @(posedge clock);
      i++;
    end
    if (completions == c0) bound_fail++;
    repeat (6) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; start is sampled on the next edge.
  task automatic run(input logic [31:0] idd, input logic [31:0] tsd,
                     input int sid, input int sts, input bit poke);
    int c0;
    c0 = completions;
    expect_run(idd, tsd, sid, sts);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    if (poke) begin
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
    wait_done(c0);
  endtask

  initial begin
    int c0;
    logic [31:0] idd;
    logic [31:0] tsd;

    #1 reset_n = 1'b0;
    c0 = completions;
    expect_run(EXP_ID, EXP_TS, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    wait_done(c0);

    run(EXP_ID, EXP_TS + 32'd1, 0, 0, 1'b0);
    run(EXP_ID, EXP_TS, 3, 0, 1'b0);
    run(EXP_ID, EXP_TS, 1000, 0, 1'b0);
    run(32'h1234_5678, EXP_TS, 0, TO - 1, 1'b0);
    run(EXP_ID, EXP_TS, 2, TO, 1'b0);
    run(EXP_ID, EXP_TS, 0, 0, 1'b1);
    run(EXP_ID, EXP_TS, 0, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      idd = ($urandom_range(0, 1) == 0) ? EXP_ID : 32'($urandom);
      tsd = ($urandom_range(0, 1) == 0) ? EXP_TS : 32'($urandom);
      run(idd, tsd, int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)), 1'b0);
    end

    // Abort a check in WAIT_TS, then let the automatic check rerun.
    expect_run(32'hDEAD_BEEF, EXP_TS, 0, 0);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    m_id = 32'd0;
    m_ts = 32'd0;
    repeat (2) @(posedge clock);
    c0 = completions;
    expect_run(EXP_ID, EXP_TS, 1, 0);
    #1 reset_n = 1'b1;
    wait_done(c0);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
